note_sequencer: RTL and testbench
=================================

# note_sequencer

Programmable melody sequencer that drives the audio tone generator. It holds a small note memory written by the host, then plays entries in order. Each entry is a note code and a duration in beat ticks. It emits the current note code to the tone generator, which converts the code to a PWM toggle divider, and supports start, stop, looping and a completion pulse.

## Interface
- `TICK_DIV`, default 6_000_000: clock cycles per beat tick (0.24 s at 25 MHz); legal range ≥ 2.
- `DEPTH`, default 32: note memory entries.
- `ADDR_W`, default 5: address width, equal to log2(`DEPTH`).

Ports:
- `clk` in 1: system clock, 25 MHz.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: write strobe for the note memory.
- `wr_addr` in `ADDR_W`: write address.
- `wr_data` in 8: entry; [7:4] note code, [3:0] length − 1 in ticks.
- `start` in 1: begin playback at address 0; ignored while `busy`.
- `stop` in 1: abort playback.
- `loop_en` in 1: restart at 0 after `last_addr`; sampled when `last_addr` completes.
- `last_addr` in `ADDR_W`: final entry of the melody; sampled at each end-of-entry check.
- `note_code` out 4: code to the tone generator; 0 = silent, 1..8 = C4..C5.
- `note_valid` out 1: high while a note or rest is being sounded.
- `busy` out 1: high outside `IDLE`.
- `play_addr` out `ADDR_W`: address of the entry currently loaded or playing.
- `done` out 1: one-cycle pulse when a non-looping melody ends.

## Operation
- State machine has three states: `IDLE`, `LOAD` and `PLAY`.
- `IDLE` → `LOAD` on `start`; sets `play_addr` = 0.
- `LOAD` lasts one cycle; the synchronous memory read of `mem[play_addr]` completes here.
  - `LOAD` → `PLAY`; registers `note_code` and the length counter `len` from the read data, and sets `note_valid` = 1.
- In `PLAY`, the tick counter runs from 0 to `TICK_DIV` − 1. A tick occurs at `TICK_DIV` − 1; the counter then wraps to 0.
  - On a tick with `len` ≠ 0: decrement `len`.
  - On a tick with `len` = 0 and `play_addr` ≠ `last_addr`: increment `play_addr`, go to `LOAD`.
  - On a tick with `len` = 0, `play_addr` = `last_addr` and `loop_en` = 1: set `play_addr` = 0, go to `LOAD`.
  - On a tick with `len` = 0, `play_addr` = `last_addr` and `loop_en` = 0: go to `IDLE`, pulse `done`, clear `note_valid` and `note_code`.
- In a between-note `LOAD`, `note_code` and `note_valid` hold the previous entry's values. There is no silent glitch between notes.
- Note code 0 is a rest: `note_valid` = 1, `note_code` = 0. Reserved codes 9..15 are output as 0.
- `stop` in any non-`IDLE` state sends the FSM to `IDLE` on the next edge. It clears `note_valid` and `note_code`, and `done` is not pulsed.
- `start` and `stop` asserted in the same cycle: `stop` wins and the FSM stays in `IDLE`.
- Memory writes are accepted in every state.
  - Read-first: a write and a read to the same address in the same cycle returns the old data.
  - Rewriting the playing entry affects only its next load.
- `play_addr` wraps naturally at `DEPTH` − 1 → 0 only through `last_addr` handling. A `last_addr` ≥ `DEPTH` is impossible by width.

## Timing
- Reset values: state `IDLE`; `note_code` = 0, `note_valid` = 0, `busy` = 0, `play_addr` = 0, `done` = 0, tick counter = 0, `len` = 0.
- Memory contents are not reset.
- Reset mid-playback returns to `IDLE` on the same edge, with no `done` pulse.
- `start` sampled at edge N:
  - `busy` = 1 after edge N.
  - `note_valid` = 1 and `note_code` valid after edge N+1.
- Entry time is (length + 1) × `TICK_DIV` cycles in `PLAY`, plus 1 `LOAD` cycle.
- First note: `note_valid` asserts 1 cycle after `busy`.
- `done` is a registered output. It is high for exactly the cycle following the final tick edge, coincident with `busy` falling.
- All outputs are registered.

## Structure
- Shared package `audio_pkg` holds:
  - the note code constants: `NOTE_REST` = 0 and `NOTE_C4`..`NOTE_C5` = 1..8;
  - the entry field positions;
  - the FSM state enum.
- The tone generator consumes the same note codes.
- One sub-module, `note_ram`: `DEPTH`×8, one write port, one synchronous read-first read port.
- The FSM, tick counter and `len` counter live in the top module.

## Test plan
All scenarios use `TICK_DIV` = 4.
- **Single pass.**
  - Stimulus: write {0x30, 0x51, 0x10}, `last_addr` = 2, `loop_en` = 0, pulse `start`.
  - Response: `note_code` sequence 3, 5, 1 for 4, 8 and 4 `PLAY` cycles; `done` pulses once; `busy` falls with `done`.
- **Loop.**
  - Stimulus: same program, `loop_en` = 1.
  - Response: after entry 2, `play_addr` returns to 0 and `note_code` returns to 3; `done` never pulses.
  - Stimulus: clear `loop_en` mid-run.
  - Response: playback ends after the next entry 2.
- **Stop.**
  - Stimulus: `stop` during entry 1.
  - Response: next cycle `note_valid` = 0, `note_code` = 0, `busy` = 0, `done` = 0.
  - Stimulus: `start` together with `stop` while idle.
  - Response: stays `IDLE`.
- **Rest and reserved codes.**
  - Stimulus: entries 0x00 and 0xC0.
  - Response: both play with `note_valid` = 1 and `note_code` = 0.
- **Write during play.**
  - Stimulus: rewrite the playing entry while `loop_en` = 1.
  - Response: the current note is unchanged; the new code appears on the next loop pass.
  - Stimulus: a same-address write in `LOAD`.
  - Response: the old data plays.
- **Reset and busy start.**
  - Stimulus: `rst` mid-`PLAY`.
  - Response: all outputs return to reset values on the next edge.
  - Stimulus: `start` while `busy`.
  - Response: ignored; `play_addr` is not reset.

Source files
------------

// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Note codes, note-memory entry layout and sequencer states
//                shared by the note sequencer and the tone generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_C4   = 4'd1;
    localparam logic [3:0] NOTE_D4   = 4'd2;
    localparam logic [3:0] NOTE_E4   = 4'd3;
    localparam logic [3:0] NOTE_F4   = 4'd4;
    localparam logic [3:0] NOTE_G4   = 4'd5;
    localparam logic [3:0] NOTE_A4   = 4'd6;
    localparam logic [3:0] NOTE_B4   = 4'd7;
    localparam logic [3:0] NOTE_C5   = 4'd8;

    // Entry layout: [7:4] note code, [3:0] length - 1 in beat ticks.
    localparam int ENTRY_W        = 8;
    localparam int ENTRY_CODE_MSB = 7;
    localparam int ENTRY_CODE_LSB = 4;
    localparam int ENTRY_LEN_MSB  = 3;
    localparam int ENTRY_LEN_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } seq_state_t;

    // Codes above C5 are reserved and are sounded as silence.
    function automatic logic [3:0] note_decode(input logic [3:0] code);
        return (code > NOTE_C5) ? NOTE_REST : code;
    endfunction

endpackage : audio_pkg
`default_nettype wire

// File: rtl/note_ram.sv
`default_nettype none
// ============================================================================
//  Module      : note_ram
//  Description : DEPTH x 8 note memory, one write port and one synchronous
//                read-first read port. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module note_ram
    import audio_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                clk,
    input  logic                i_wr_en,
    input  logic [ADDR_W-1:0]   i_wr_addr,
    input  logic [ENTRY_W-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0]   i_rd_addr,
    output logic [ENTRY_W-1:0]  o_rd_data
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [ENTRY_W-1:0] r_rd_data;

    // Both updates are non-blocking, so a same-address write returns old data.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule : note_ram
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : note_sequencer
//  Description : Plays note-memory entries in order for (len+1) beat ticks
//                each, with start/stop, looping and a completion pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module note_sequencer
    import audio_pkg::*;
#(
    parameter int TICK_DIV = 6_000_000,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [7:0]          wr_data,
    input  logic                start,
    input  logic                stop,
    input  logic                loop_en,
    input  logic [ADDR_W-1:0]   last_addr,
    output logic [3:0]          note_code,
    output logic                note_valid,
    output logic                busy,
    output logic [ADDR_W-1:0]   play_addr,
    output logic                done
);

    localparam int               c_cnt_w     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_tick_last = c_cnt_w'(TICK_DIV - 1);

    seq_state_t          r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_play_addr, w_addr_nxt;
    logic [c_cnt_w-1:0]  r_tick_cnt, w_tick_cnt_nxt;
    logic [3:0]          r_len, w_len_nxt;
    logic [3:0]          r_note_code, w_code_nxt;
    logic                r_note_valid, w_valid_nxt;
    logic                r_done, w_done_nxt;
    logic                r_busy;
    logic                w_tick;
    logic [ENTRY_W-1:0]  w_rd_data;

    // The read address is the next play address, so the entry for a LOAD
    // cycle is already on the read port while the FSM sits in LOAD.
    note_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_note_ram (
        .clk       (clk),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (w_addr_nxt),
        .o_rd_data (w_rd_data)
    );

    assign w_tick = (r_tick_cnt == c_tick_last);

    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_play_addr;
        w_tick_cnt_nxt = '0;
        w_len_nxt      = r_len;
        w_code_nxt     = r_note_code;
        w_valid_nxt    = r_note_valid;
        w_done_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = ST_LOAD;
                    w_addr_nxt  = '0;
                end
            end

            ST_LOAD: begin
                w_state_nxt = ST_PLAY;
                w_code_nxt  = note_decode(w_rd_data[ENTRY_CODE_MSB:ENTRY_CODE_LSB]);
                w_len_nxt   = w_rd_data[ENTRY_LEN_MSB:ENTRY_LEN_LSB];
                w_valid_nxt = 1'b1;
            end

            ST_PLAY: begin
                w_tick_cnt_nxt = w_tick ? '0 : r_tick_cnt + 1'b1;
                if (w_tick) begin
                    if (r_len != 4'd0) begin
                        w_len_nxt = r_len - 1'b1;
                    end else if (r_play_addr != last_addr) begin
                        w_addr_nxt  = r_play_addr + 1'b1;
                        w_state_nxt = ST_LOAD;
                    end else if (loop_en) begin
                        w_addr_nxt  = '0;
                        w_state_nxt = ST_LOAD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                        w_code_nxt  = NOTE_REST;
                        w_valid_nxt = 1'b0;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_code_nxt  = NOTE_REST;
                w_valid_nxt = 1'b0;
            end
        endcase

        // An abort overrides everything, including an end-of-melody done.
        if (stop && (r_state != ST_IDLE)) begin
            w_state_nxt    = ST_IDLE;
            w_addr_nxt     = r_play_addr;
            w_tick_cnt_nxt = '0;
            w_code_nxt     = NOTE_REST;
            w_valid_nxt    = 1'b0;
            w_done_nxt     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_play_addr  <= '0;
            r_tick_cnt   <= '0;
            r_len        <= 4'd0;
            r_note_code  <= NOTE_REST;
            r_note_valid <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_play_addr  <= w_addr_nxt;
            r_tick_cnt   <= w_tick_cnt_nxt;
            r_len        <= w_len_nxt;
            r_note_code  <= w_code_nxt;
            r_note_valid <= w_valid_nxt;
            r_done       <= w_done_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
        end
    end

    assign note_code  = r_note_code;
    assign note_valid = r_note_valid;
    assign busy       = r_busy;
    assign play_addr  = r_play_addr;
    assign done       = r_done;

endmodule : note_sequencer
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_note_sequencer
//  Description : Directed vector bench for note_sequencer with TICK_DIV = 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_note_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop_en = 1'b0;
    logic [4:0] last_addr = '0;
    logic [3:0] note_code;
    logic       note_valid;
    logic       busy;
    logic [4:0] play_addr;
    logic       done;

    int checks = 0;
    int passes = 0;

    note_sequencer #(
        .TICK_DIV (4),
        .DEPTH    (32),
        .ADDR_W   (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .last_addr  (last_addr),
        .note_code  (note_code),
        .note_valid (note_valid),
        .busy       (busy),
        .play_addr  (play_addr),
        .done       (done)
    );

    always #5 clk = ~clk;

    // One row: inputs held for n edges, expected outputs after each edge.
    typedef struct {
        int         n;
        logic       rst, start, stop, lp, wr;
        logic [4:0] wa;
        logic [7:0] wd;
        logic       busy, valid;
        logic [3:0] code;
        logic [4:0] addr;
        logic       done;
    } vec_t;

    vec_t       q[$];
    logic       pend_wr = 1'b0;
    logic [4:0] pend_wa = '0;
    logic [7:0] pend_wd = '0;

    task automatic set_wr(input logic [4:0] a, input logic [7:0] d);
        pend_wr = 1'b1;
        pend_wa = a;
        pend_wd = d;
    endtask

    task automatic add(input int n, input logic r, input logic s, input logic p,
                       input logic lp, input logic b, input logic v,
                       input logic [3:0] c, input logic [4:0] a, input logic d);
        vec_t t;
        t.n = n; t.rst = r; t.start = s; t.stop = p; t.lp = lp;
        t.wr = pend_wr; t.wa = pend_wa; t.wd = pend_wd;
        t.busy = b; t.valid = v; t.code = c; t.addr = a; t.done = d;
        q.push_back(t);
        pend_wr = 1'b0;
    endtask

    task automatic run(input string name);
        foreach (q[i]) begin
            for (int r = 0; r < q[i].n; r++) begin
                rst     = q[i].rst;
                start   = q[i].start;
                stop    = q[i].stop;
                loop_en = q[i].lp;
                wr_en   = q[i].wr && (r == 0);
                wr_addr = q[i].wa;
                wr_data = q[i].wd;
                @(posedge clk);
                #1;
                checks++;
                if ({busy, note_valid, note_code, play_addr, done} ===
                    {q[i].busy, q[i].valid, q[i].code, q[i].addr, q[i].done}) begin
                    passes++;
                end else begin
                    $display("FAIL %s row %0d cyc %0d: got busy=%b valid=%b code=%0d addr=%0d done=%b, expected busy=%b valid=%b code=%0d addr=%0d done=%b",
                             name, i, r, busy, note_valid, note_code, play_addr, done,
                             q[i].busy, q[i].valid, q[i].code, q[i].addr, q[i].done);
                end
            end
        end
        q.delete();
        rst = 1'b0; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    endtask

    task automatic mem_write(input logic [4:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic program_song;
        mem_write(5'd0, 8'h30);
        mem_write(5'd1, 8'h51);
        mem_write(5'd2, 8'h10);
        last_addr = 5'd2;
    endtask

    initial begin
        // Reset state.
        add(2, 1, 0, 0, 0, 0, 0, 4'd0, 5'd0, 0);
        run("reset");

        // Single pass: 3 for 4, 5 for 8, 1 for 4 PLAY cycles, then done.
        program_song();
        add(1, 0, 1, 0, 0, 1, 0, 4'd0, 5'd0, 0);
        add(4, 0, 0, 0, 0, 1, 1, 4'd3, 5'd0, 0);
        add(1, 0, 0, 0, 0, 1, 1, 4'd3, 5'd1, 0);
        add(8, 0, 0, 0, 0, 1, 1, 4'd5, 5'd1, 0);
        add(1, 0, 0, 0, 0, 1, 1, 4'd5, 5'd2, 0);
        add(4, 0, 0, 0, 0, 1, 1, 4'd1, 5'd2, 0);
        add(1, 0, 0, 0, 0, 0, 0, 4'd0, 5'd2, 1);
        add(2, 0, 0, 0, 0, 0, 0, 4'd0, 5'd2, 0);
        run("single");

        // Loop, then loop_en cleared during the second pass.
        add(1, 0, 1, 0, 1, 1, 0, 4'd0, 5'd0, 0);
        add(4, 0, 0, 0, 1, 1, 1, 4'd3, 5'd0, 0);
        add(1, 0, 0, 0, 1, 1, 1, 4'd3, 5'd1, 0);
        add(8, 0, 0, 0, 1, 1, 1, 4'd5, 5'd1, 0);
        add(1, 0, 0, 0, 1, 1, 1, 4'd5, 5'd2, 0);
        add(4, 0, 0, 0, 1, 1, 1, 4'd1, 5'd2, 0);
        add(1, 0, 0, 0, 1, 1, 1, 4'd1, 5'd0, 0);
        add(4, 0, 0, 0, 0, 1, 1, 4'd3, 5'd0, 0);
        add(1, 0, 0, 0, 0, 1, 1, 4'd3, 5'd1, 0);
        add(8, 0, 0, 0, 0, 1, 1, 4'd5, 5'd1, 0);
        add(1, 0, 0, 0, 0, 1, 1, 4'd5, 5'd2, 0);
        add(4, 0, 0, 0, 0, 1, 1, 4'd1, 5'd2, 0);
        add(1, 0, 0, 0, 0, 0, 0, 4'd0, 5'd2, 1);
        add(1, 0, 0, 0, 0, 0, 0, 4'd0, 5'd2, 0);
        run("loop");

        // Stop during entry 1, then start+stop together while idle.
        add(1, 0, 1, 0, 0, 1, 0, 4'd0, 5'd0, 0);
        add(4, 0, 0, 0, 0, 1, 1, 4'd3, 5'd0, 0);
        add(1, 0, 0, 0, 0, 1, 1, 4'd3, 5'd1, 0);
        add(2, 0, 0, 0, 0, 1, 1, 4'd5, 5'd1, 0);
        add(1, 0, 0, 1, 0, 0, 0, 4'd0, 5'd1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 4'd0, 5'd1, 0);
        add(1, 0, 1, 1, 0, 0, 0, 4'd0, 5'd1, 0);
        add(2, 0, 0, 0, 0, 0, 0, 4'd0, 5'd1, 0);
        run("stop");

        // Rest (0x00) and reserved code (0xC0) both sound as valid silence.
        mem_write(5'd0, 8'h00);
        mem_write(5'd1, 8'hC0);
        last_addr = 5'd1;
        add(1, 0, 1, 0, 0, 1, 0, 4'd0, 5'd0, 0);
        add(4, 0, 0, 0, 0, 1, 1, 4'd0, 5'd0, 0);
        add(1, 0, 0, 0, 0, 1, 1, 4'd0, 5'd1, 0);
        add(4, 0, 0, 0, 0, 1, 1, 4'd0, 5'd1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 4'd0, 5'd1, 1);
        add(1, 0, 0, 0, 0, 0, 0, 4'd0, 5'd1, 0);
        run("rest");

        // Rewrite the playing entry and write the loading entry.
        program_song();
        add(1, 0, 1, 0, 1, 1, 0, 4'd0, 5'd0, 0);
        set_wr(5'd0, 8'h70);
        add(1, 0, 0, 0, 1, 1, 1, 4'd3, 5'd0, 0);
        add(3, 0, 0, 0, 1, 1, 1, 4'd3, 5'd0, 0);
        add(1, 0, 0, 0, 1, 1, 1, 4'd3, 5'd1, 0);
        set_wr(5'd1, 8'h20);
        add(1, 0, 0, 0, 1, 1, 1, 4'd5, 5'd1, 0);
        add(7, 0, 0, 0, 1, 1, 1, 4'd5, 5'd1, 0);
        add(1, 0, 0, 0, 1, 1, 1, 4'd5, 5'd2, 0);
        add(4, 0, 0, 0, 1, 1, 1, 4'd1, 5'd2, 0);
        add(1, 0, 0, 0, 1, 1, 1, 4'd1, 5'd0, 0);
        add(4, 0, 0, 0, 0, 1, 1, 4'd7, 5'd0, 0);
        add(1, 0, 0, 0, 0, 1, 1, 4'd7, 5'd1, 0);
        add(4, 0, 0, 0, 0, 1, 1, 4'd2, 5'd1, 0);
        add(1, 0, 0, 0, 0, 1, 1, 4'd2, 5'd2, 0);
        add(4, 0, 0, 0, 0, 1, 1, 4'd1, 5'd2, 0);
        add(1, 0, 0, 0, 0, 0, 0, 4'd0, 5'd2, 1);
        add(1, 0, 0, 0, 0, 0, 0, 4'd0, 5'd2, 0);
        run("wrplay");

        // Start while busy is ignored; reset mid-play clears everything.
        program_song();
        add(1, 0, 1, 0, 0, 1, 0, 4'd0, 5'd0, 0);
        add(4, 0, 0, 0, 0, 1, 1, 4'd3, 5'd0, 0);
        add(1, 0, 0, 0, 0, 1, 1, 4'd3, 5'd1, 0);
        add(2, 0, 1, 0, 0, 1, 1, 4'd5, 5'd1, 0);
        add(1, 1, 0, 0, 0, 0, 0, 4'd0, 5'd0, 0);
        add(2, 0, 0, 0, 0, 0, 0, 4'd0, 5'd0, 0);
        run("rstbusy");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_note_sequencer
`default_nettype wire
